// File: rtl/mmio_byte_streamer_pkg.sv
// -----------------------------------------------------------------------------
// mmio_byte_streamer_pkg
// Shared definitions for the MMIO byte streamer: bus width, register offsets
// relative to BASE_ADDR, STATUS bit positions, transmitter state encoding and
// a helper that assembles the STATUS word.
// -----------------------------------------------------------------------------
package mmio_byte_streamer_pkg;

    localparam int BIT_WIDTH = 32;

    localparam logic [BIT_WIDTH-1:0] TXDATA_OFS = 32'd0;
    localparam logic [BIT_WIDTH-1:0] STATUS_OFS = 32'd1;

    localparam int ST_EMPTY_BIT = 0;
    localparam int ST_FULL_BIT  = 1;
    localparam int ST_BUSY_BIT  = 2;
    localparam int ST_OVF_BIT   = 3;
    localparam int ST_COUNT_LSB = 8;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETUP  = 3'd1,
        S_STROBE = 3'd2,
        S_HOLD   = 3'd3,
        S_DONE   = 3'd4
    } tx_state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

    function automatic logic [BIT_WIDTH-1:0] pack_status(
        input logic [7:0] count,
        input logic       ovf,
        input logic       busy,
        input logic       full,
        input logic       empty
    );
        logic [BIT_WIDTH-1:0] s;
        s = '0;
        s[ST_COUNT_LSB +: 8] = count;
        s[ST_OVF_BIT]        = ovf;
        s[ST_BUSY_BIT]       = busy;
        s[ST_FULL_BIT]       = full;
        s[ST_EMPTY_BIT]      = empty;
        return s;
    endfunction

endpackage

// File: rtl/mmio_byte_streamer_if.sv
// -----------------------------------------------------------------------------
// mmio_byte_streamer_if
// CPU-side memory-mapped bus as seen by the byte streamer.
//   AddressBus  : word address from the CPU
//   DataBusOut  : CPU write data (streamer uses [7:0])
//   MemWriteEn  : write strobe
//   MemReadEn   : read strobe
//   RdData      : registered read data from the peripheral
//   RdValid     : RdData holds a hit for this peripheral
// master = CPU side, slave = peripheral side.
// -----------------------------------------------------------------------------
interface mmio_byte_streamer_if;
    import mmio_byte_streamer_pkg::*;

    logic [BIT_WIDTH-1:0] AddressBus;
    logic [BIT_WIDTH-1:0] DataBusOut;
    logic                 MemWriteEn;
    logic                 MemReadEn;
    logic [BIT_WIDTH-1:0] RdData;
    logic                 RdValid;

    modport master (
        output AddressBus, DataBusOut, MemWriteEn, MemReadEn,
        input  RdData, RdValid
    );

    modport slave (
        input  AddressBus, DataBusOut, MemWriteEn, MemReadEn,
        output RdData, RdValid
    );

endinterface

// File: rtl/mmio_byte_streamer_byte_fifo.sv
// -----------------------------------------------------------------------------
// mmio_byte_streamer_byte_fifo
// Synchronous 8-bit FIFO, DEPTH entries (power of two, >= 2).
//   clk      : system clock
//   rst      : asynchronous active-low reset (empties the FIFO)
//   i_push   : write i_data (caller only pushes when not full or popping)
//   i_pop    : advance the read pointer (caller only pops when not empty)
//   i_data   : byte to write
//   o_data   : byte at the head of the FIFO
//   o_full   : FIFO full
//   o_empty  : FIFO empty
//   o_count  : number of stored bytes
// -----------------------------------------------------------------------------
module mmio_byte_streamer_byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic [7:0]                 i_data,
    output logic [7:0]                 o_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]  r_mem [DEPTH];
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign o_data  = r_mem[r_rd_ptr[AW-1:0]];
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_count = r_wr_ptr - r_rd_ptr;

endmodule

// File: rtl/mmio_byte_streamer.sv
// -----------------------------------------------------------------------------
// mmio_byte_streamer
// Memory-mapped byte transmitter. The CPU writes bytes to TXDATA
// (BASE_ADDR); they are queued in a FIFO and sent on an 8-bit parallel port
// with a data-qualified strobe. A 0x00 byte ends a frame and produces a
// one-cycle frame_done pulse after its hold time.
//   clk          : system clock
//   rst          : asynchronous active-low reset
//   bus          : CPU bus (slave modport)
//   port_data    : byte on the parallel port
//   port_strobe  : byte-valid strobe
//   frame_done   : one-cycle pulse after a null byte finishes
//   busy         : transmitter active or bytes queued
//
// state    | meaning
// ---------+--------------------------------------------------------
// S_IDLE   | waiting for a queued byte; port_data keeps last byte
// S_SETUP  | new byte on port_data, strobe low
// S_STROBE | strobe high
// S_HOLD   | strobe low, data still held
// S_DONE   | null byte finished, frame_done high for one cycle
// -----------------------------------------------------------------------------
module mmio_byte_streamer
    import mmio_byte_streamer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR     = 32'h0000_0400,
    parameter int          FIFO_DEPTH    = 16,
    parameter int          SETUP_CYCLES  = 2,
    parameter int          STROBE_CYCLES = 4,
    parameter int          HOLD_CYCLES   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    mmio_byte_streamer_if.slave   bus,
    output logic [7:0]            port_data,
    output logic                  port_strobe,
    output logic                  frame_done,
    output logic                  busy
);

    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int CNT_MAX = max3(SETUP_CYCLES, STROBE_CYCLES, HOLD_CYCLES);
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    tx_state_e            r_state;
    tx_state_e            w_state_nxt;
    logic [CW-1:0]        r_cnt;
    logic [CW-1:0]        w_cnt_nxt;
    logic [7:0]           r_port_data;
    logic [7:0]           w_data_nxt;
    logic                 r_strobe;
    logic                 w_strobe_nxt;
    logic                 r_ovf;
    logic [BIT_WIDTH-1:0] r_rd_data;
    logic                 r_rd_valid;

    logic                 w_hit_tx;
    logic                 w_hit_st;
    logic                 w_push_req;
    logic                 w_push_ok;
    logic                 w_pop;
    logic                 w_ovf_set;
    logic                 w_ovf_clr;
    logic [7:0]           w_head;
    logic                 w_full;
    logic                 w_empty;
    logic [AW:0]          w_count;
    logic [BIT_WIDTH-1:0] w_status;
    logic                 w_unused;

    assign w_hit_tx   = (bus.AddressBus == BASE_ADDR + TXDATA_OFS);
    assign w_hit_st   = (bus.AddressBus == BASE_ADDR + STATUS_OFS);
    assign w_push_req = bus.MemWriteEn & w_hit_tx;
    // A full FIFO still accepts a byte when the FSM pops in the same cycle.
    assign w_push_ok  = w_push_req & (~w_full | w_pop);
    assign w_ovf_set  = w_push_req & ~w_push_ok;
    assign w_ovf_clr  = bus.MemWriteEn & w_hit_st;
    assign w_unused   = &{1'b0, bus.DataBusOut[BIT_WIDTH-1:8]};

    mmio_byte_streamer_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push_ok),
        .i_pop   (w_pop),
        .i_data  (bus.DataBusOut[7:0]),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_port_data <= '0;
            r_strobe    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_port_data <= w_data_nxt;
            r_strobe    <= w_strobe_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_data_nxt   = r_port_data;
        w_strobe_nxt = r_strobe;
        w_pop        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_data_nxt  = w_head;
                    w_cnt_nxt   = CW'(SETUP_CYCLES - 1);
                    w_state_nxt = S_SETUP;
                end
            end
            S_SETUP: begin
                if (r_cnt == '0) begin
                    w_strobe_nxt = 1'b1;
                    w_cnt_nxt    = CW'(STROBE_CYCLES - 1);
                    w_state_nxt  = S_STROBE;
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            S_STROBE: begin
                if (r_cnt == '0) begin
                    w_strobe_nxt = 1'b0;
                    w_cnt_nxt    = CW'(HOLD_CYCLES - 1);
                    w_state_nxt  = S_HOLD;
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            S_HOLD: begin
                if (r_cnt == '0) begin
                    w_state_nxt = (r_port_data == 8'h00) ? S_DONE : S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt  = S_IDLE;
                w_strobe_nxt = 1'b0;
                w_cnt_nxt    = '0;
            end
        endcase
    end

    // Set wins over a simultaneous clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ovf <= 1'b0;
        end else if (w_ovf_set) begin
            r_ovf <= 1'b1;
        end else if (w_ovf_clr) begin
            r_ovf <= 1'b0;
        end
    end

    assign w_status = pack_status(8'(w_count), r_ovf, busy, w_full, w_empty);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= bus.MemReadEn & (w_hit_tx | w_hit_st);
            if (bus.MemReadEn & w_hit_st) begin
                r_rd_data <= w_status;
            end else if (bus.MemReadEn & w_hit_tx) begin
                r_rd_data <= '0;
            end
        end
    end

    assign bus.RdData  = r_rd_data;
    assign bus.RdValid = r_rd_valid;
    assign port_data   = r_port_data;
    assign port_strobe = r_strobe;
    assign frame_done  = (r_state == S_DONE);
    assign busy        = (r_state != S_IDLE) | ~w_empty;

endmodule
